// File: rtl/fft_bfly_sched.sv
// Butterfly sequencer for a radix-2 DIT in-place FFT: issues operand/twiddle reads,
// tracks in-flight butterflies in an address FIFO and returns writeback addresses.
module fft_bfly_sched #(
  parameter int unsigned LOG2N = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SW    = $clog2(LOG2N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             hold_i,
  input  logic             mult_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SW-1:0]    stage_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic             mult_valid_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o,
  output logic             err_o
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [KW-1:0] KMAX = {KW{1'b1}};
  localparam logic [SW-1:0] LAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e           state;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [LOG2N-1:0] fifo_a [DEPTH];
  logic [LOG2N-1:0] fifo_b [DEPTH];

  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [SW-1:0]    tw_sh;
  logic [KW-1:0]    tw;

  // Butterfly address generation: insert a zero at bit position 'stage' of k.
  always_comb begin
    half   = LOG2N'(1) << stage_o;
    mask   = half - LOG2N'(1);
    k_ext  = LOG2N'(k);
    addr_a = ((k_ext & ~mask) << 1) | (k_ext & mask);
    addr_b = addr_a | half;
    tw_sh  = LAST - stage_o;
    tw     = KW'(k & KW'(mask)) << tw_sh;
  end

  assign rd_en_o     = (state == S_ISSUE) && !hold_i && (cnt < CW'(DEPTH));
  assign rd_addr_a_o = rd_en_o ? addr_a : '0;
  assign rd_addr_b_o = rd_en_o ? addr_b : '0;
  assign tw_addr_o   = rd_en_o ? tw : '0;

  assign wr_en_o     = mult_valid_i && (cnt != '0);
  assign wr_addr_a_o = wr_en_o ? fifo_a[rptr] : '0;
  assign wr_addr_b_o = wr_en_o ? fifo_b[rptr] : '0;

  // Outstanding count doubles as FIFO occupancy.
  always_comb begin
    cnt_nxt = cnt;
    unique case ({rd_en_o, wr_en_o})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_o) begin
      fifo_a[wptr] <= addr_a;
      fifo_b[wptr] <= addr_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      stage_o      <= '0;
      k            <= '0;
      cnt          <= '0;
      wptr         <= '0;
      rptr         <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      mult_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      mult_valid_o <= rd_en_o;
      done_o       <= 1'b0;
      cnt          <= cnt_nxt;
      if (rd_en_o) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      if (wr_en_o) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);

      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state   <= S_ISSUE;
            stage_o <= '0;
            k       <= '0;
            busy_o  <= 1'b1;
            err_o   <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (rd_en_o) begin
            k <= k + KW'(1);
            if (k == KMAX) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Stage boundary waits for every writeback to land (RAW hazard).
          if (cnt_nxt == '0) begin
            if (stage_o == LAST) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              stage_o <= stage_o + SW'(1);
              k       <= '0;
              state   <= S_ISSUE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Sticky error; a stray result in the same cycle as start still flags.
      if (mult_valid_i && ((cnt == '0) || (state == S_IDLE))) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched at N=8: two instances (DEPTH 8 and 2) fed by a
// 5-cycle multiplier model, checked against hand-computed address tables.
module tb_fft_bfly_sched;

  localparam int unsigned LOG2N = 3;
  localparam int unsigned SW    = 2;
  localparam int unsigned LAT   = 5;
  localparam int          NB    = 12;

  logic clk = 1'b0;
  logic rst_n, start, hold, inject;

  logic             mv_in  [2];
  logic             busy   [2];
  logic             done   [2];
  logic [SW-1:0]    stage  [2];
  logic             rd_en  [2];
  logic [LOG2N-1:0] rd_a   [2];
  logic [LOG2N-1:0] rd_b   [2];
  logic [LOG2N-2:0] tw     [2];
  logic             mv_out [2];
  logic             wr_en  [2];
  logic [LOG2N-1:0] wr_a   [2];
  logic [LOG2N-1:0] wr_b   [2];
  logic             err    [2];
  logic [LAT-1:0]   pipe   [2];

  int total, bad;
  int rd_idx [2];
  int wr_idx [2];
  int passes [2];
  logic prev_rd [2];

  int exp_a  [NB] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b  [NB] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw [NB] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  int depth  [2]  = '{8, 2};

  always #5 clk = ~clk;

  fft_bfly_sched #(.LOG2N(LOG2N), .DEPTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold), .mult_valid_i(mv_in[0]),
    .busy_o(busy[0]), .done_o(done[0]), .stage_o(stage[0]), .rd_en_o(rd_en[0]),
    .rd_addr_a_o(rd_a[0]), .rd_addr_b_o(rd_b[0]), .tw_addr_o(tw[0]), .mult_valid_o(mv_out[0]),
    .wr_en_o(wr_en[0]), .wr_addr_a_o(wr_a[0]), .wr_addr_b_o(wr_b[0]), .err_o(err[0])
  );

  fft_bfly_sched #(.LOG2N(LOG2N), .DEPTH(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold), .mult_valid_i(mv_in[1]),
    .busy_o(busy[1]), .done_o(done[1]), .stage_o(stage[1]), .rd_en_o(rd_en[1]),
    .rd_addr_a_o(rd_a[1]), .rd_addr_b_o(rd_b[1]), .tw_addr_o(tw[1]), .mult_valid_o(mv_out[1]),
    .wr_en_o(wr_en[1]), .wr_addr_a_o(wr_a[1]), .wr_addr_b_o(wr_b[1]), .err_o(err[1])
  );

  // Multiplier model: result strobe LAT cycles after the read issue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
    end else begin
      pipe[0] <= {pipe[0][LAT-2:0], rd_en[0]};
      pipe[1] <= {pipe[1][LAT-2:0], rd_en[1]};
    end
  end
  assign mv_in[0] = pipe[0][LAT-1] | inject;
  assign mv_in[1] = pipe[1][LAT-1] | inject;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_busy%0d", tag, i),  32'(busy[i]),   32'd0);
      check($sformatf("%s_done%0d", tag, i),  32'(done[i]),   32'd0);
      check($sformatf("%s_stage%0d", tag, i), 32'(stage[i]),  32'd0);
      check($sformatf("%s_rden%0d", tag, i),  32'(rd_en[i]),  32'd0);
      check($sformatf("%s_rdab%0d", tag, i),  32'({rd_a[i], rd_b[i], tw[i]}), 32'd0);
      check($sformatf("%s_mvo%0d", tag, i),   32'(mv_out[i]), 32'd0);
      check($sformatf("%s_wren%0d", tag, i),  32'(wr_en[i]),  32'd0);
      check($sformatf("%s_wrab%0d", tag, i),  32'({wr_a[i], wr_b[i]}), 32'd0);
      check($sformatf("%s_err%0d", tag, i),   32'(err[i]),    32'd0);
    end
  endtask

  // Event monitor: read/write order against the tables, hazards, depth, hold.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rd_idx[i]  = 0;
        wr_idx[i]  = 0;
        prev_rd[i] = 1'b0;
      end else begin
        if (mv_out[i] || prev_rd[i]) check($sformatf("mvo_lag%0d", i), 32'(mv_out[i]), 32'(prev_rd[i]));
        if (hold) check($sformatf("hold_rd%0d", i), 32'(rd_en[i]), 32'd0);
        if (rd_en[i]) begin
          if (rd_idx[i] < NB) begin
            check($sformatf("rd_a%0d_%0d", i, rd_idx[i]),  32'(rd_a[i]),  32'(exp_a[rd_idx[i]]));
            check($sformatf("rd_b%0d_%0d", i, rd_idx[i]),  32'(rd_b[i]),  32'(exp_b[rd_idx[i]]));
            check($sformatf("tw%0d_%0d", i, rd_idx[i]),    32'(tw[i]),    32'(exp_tw[rd_idx[i]]));
            check($sformatf("stage%0d_%0d", i, rd_idx[i]), 32'(stage[i]), 32'(rd_idx[i] / 4));
            if (rd_idx[i] % 4 == 0)
              check($sformatf("hazard%0d_%0d", i, rd_idx[i]), 32'(wr_idx[i]), 32'(rd_idx[i]));
            check($sformatf("depth%0d", i), 32'(rd_idx[i] - wr_idx[i] < depth[i]), 32'd1);
          end else begin
            check($sformatf("rd_extra%0d", i), 32'(rd_idx[i]), 32'(NB - 1));
          end
          rd_idx[i]++;
        end
        if (wr_en[i]) begin
          if (wr_idx[i] < NB) begin
            check($sformatf("wr_a%0d_%0d", i, wr_idx[i]), 32'(wr_a[i]), 32'(exp_a[wr_idx[i]]));
            check($sformatf("wr_b%0d_%0d", i, wr_idx[i]), 32'(wr_b[i]), 32'(exp_b[wr_idx[i]]));
          end else begin
            check($sformatf("wr_extra%0d", i), 32'(wr_idx[i]), 32'(NB - 1));
          end
          wr_idx[i]++;
        end
        if (done[i]) begin
          check($sformatf("done_rds%0d", i), 32'(rd_idx[i]), 32'(NB));
          check($sformatf("done_wrs%0d", i), 32'(wr_idx[i]), 32'(NB));
          check($sformatf("done_busy%0d", i), 32'(busy[i]), 32'd0);
          passes[i]++;
          rd_idx[i] = 0;
          wr_idx[i] = 0;
        end
        prev_rd[i] = rd_en[i];
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_pass(input int target);
    int n;
    n = 0;
    while ((passes[0] < target || passes[1] < target) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check($sformatf("passes8_%0d", target), 32'(passes[0]), 32'(target));
    check($sformatf("passes2_%0d", target), 32'(passes[1]), 32'(target));
    check("idle_busy8", 32'(busy[0]), 32'd0);
    check("idle_busy2", 32'(busy[1]), 32'd0);
    check("idle_err8",  32'(err[0]),  32'd0);
    check("idle_err2",  32'(err[1]),  32'd0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    passes[0] = 0; passes[1] = 0;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass 1: hold for 3 cycles after the second stage-0 issue.
    pulse_start();
    check("start_busy8", 32'(busy[0]), 32'd1);
    check("start_busy2", 32'(busy[1]), 32'd1);
    n = 0;
    while (rd_idx[0] < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_at", 32'(rd_idx[0]), 32'd2);
    hold = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    hold = 1'b0;
    check("hold_frozen", 32'(rd_idx[0]), 32'd2);
    wait_pass(1);

    // Stray multiplier result while idle.
    inject = 1'b1;
    @(negedge clk);
    check("inj_wren8", 32'(wr_en[0]), 32'd0);
    check("inj_wren2", 32'(wr_en[1]), 32'd0);
    @(posedge clk); #1;
    inject = 1'b0;
    @(posedge clk); #1;
    check("inj_err8", 32'(err[0]), 32'd1);
    check("inj_err2", 32'(err[1]), 32'd1);
    pulse_start();
    check("clr_err8", 32'(err[0]), 32'd0);
    check("clr_err2", 32'(err[1]), 32'd0);
    wait_pass(2);

    // Pass 3 aborted by reset in stage 1, then a clean restart.
    pulse_start();
    n = 0;
    while (!(stage[0] == SW'(1) && rd_idx[0] >= 6) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_stage", 32'(stage[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_quiet("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_rdidx", 32'(rd_idx[0]), 32'd0);
    pulse_start();
    wait_pass(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
